// File: rtl/pong_score_keeper_if.sv
// Pong score keeper bus.
// Groups the ball-exit / new-game inputs and the score, strobe, serve and
// game-over outputs of the score keeper into one bundle.
//   master : ball/paddle logic side (drives ball events and new_game, reads results)
//   slave  : score keeper side
interface pong_score_keeper_if;
    logic       ball_out_left;
    logic       ball_out_right;
    logic       new_game;
    logic [2:0] p1_score;
    logic [2:0] p2_score;
    logic       p1_scored;
    logic       p2_scored;
    logic       serve_hold;
    logic       serve_dir;
    logic       game_over;
    logic       winner;

    modport master (
        output ball_out_left, ball_out_right, new_game,
        input  p1_score, p2_score, p1_scored, p2_scored,
               serve_hold, serve_dir, game_over, winner
    );

    modport slave (
        input  ball_out_left, ball_out_right, new_game,
        output p1_score, p2_score, p1_scored, p2_scored,
               serve_hold, serve_dir, game_over, winner
    );
endinterface

// File: rtl/pong_score_keeper.sv
// Pong score keeper.
// Converts ball-exit levels into per-player 3-bit scores with "scored"
// strobes, and sequences serve pause / play / game over.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : pong_score_keeper_if.slave
//          in : ball_out_left (P2 point), ball_out_right (P1 point), new_game
//          out: p1_score, p2_score, p1_scored, p2_scored, serve_hold,
//               serve_dir (1 = toward P2), game_over, winner (1 = P2)
//
// state      | meaning
// SERVE_WAIT | ball frozen at centre, serve counter running
// PLAY       | ball live, watching for exit edges
// GAME_OVER  | a player reached WIN_SCORE, scores frozen until new_game
module pong_score_keeper #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 50_000_000,
    parameter int CNT_WIDTH   = 26,
    parameter int PULSE_LEN   = 4
) (
    input  logic               clk,
    input  logic               rst,
    pong_score_keeper_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(SERVE_DELAY - 1);
    localparam logic [2:0]           WIN_VAL   = 3'(WIN_SCORE);
    localparam logic [3:0]           PULSE_VAL = 4'(PULSE_LEN);

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'd0,
        PLAY       = 2'd1,
        GAME_OVER  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic [2:0]           p1_q, p1_nx;
    logic [2:0]           p2_q, p2_nx;
    logic [3:0]           pulse_cnt, pulse_nx;
    logic                 strobe_p2, strobe_p2_nx;
    logic                 dir_q, dir_nx;
    logic                 win_q, win_nx;
    logic                 p1_scored_q, p2_scored_q;
    logic                 hold_q, game_over_q;

    logic left_prev, right_prev, ng_prev;
    logic left_ev, right_ev, ng_ev;

    // Edge detectors run in every state so a level held across a state
    // change never produces a late event.
    assign left_ev  = bus.ball_out_left  & ~left_prev;
    assign right_ev = bus.ball_out_right & ~right_prev;
    assign ng_ev    = bus.new_game       & ~ng_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SERVE_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        p1_nx        = p1_q;
        p2_nx        = p2_q;
        dir_nx       = dir_q;
        win_nx       = win_q;
        strobe_p2_nx = strobe_p2;
        pulse_nx     = (pulse_cnt != 4'd0) ? 4'(pulse_cnt - 4'd1) : 4'd0;

        if (ng_ev) begin
            state_nx = SERVE_WAIT;
            cnt_nx   = '0;
            p1_nx    = 3'd0;
            p2_nx    = 3'd0;
            dir_nx   = 1'b0;
            pulse_nx = 4'd0;
        end else begin
            case (state)
                SERVE_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        state_nx = PLAY;
                    end else begin
                        cnt_nx = cnt + CNT_WIDTH'(1);
                    end
                end
                PLAY: begin
                    if (left_ev && right_ev) begin
                        // Simultaneous exits are ambiguous: re-serve, nobody scores.
                        state_nx = SERVE_WAIT;
                    end else if (right_ev) begin
                        p1_nx        = p1_q + 3'd1;
                        pulse_nx     = PULSE_VAL;
                        strobe_p2_nx = 1'b0;
                        dir_nx       = 1'b1;
                        if (p1_nx == WIN_VAL) begin
                            state_nx = GAME_OVER;
                            win_nx   = 1'b0;
                        end else begin
                            state_nx = SERVE_WAIT;
                        end
                    end else if (left_ev) begin
                        p2_nx        = p2_q + 3'd1;
                        pulse_nx     = PULSE_VAL;
                        strobe_p2_nx = 1'b1;
                        dir_nx       = 1'b0;
                        if (p2_nx == WIN_VAL) begin
                            state_nx = GAME_OVER;
                            win_nx   = 1'b1;
                        end else begin
                            state_nx = SERVE_WAIT;
                        end
                    end
                end
                GAME_OVER: begin
                end
                default: begin
                    state_nx = SERVE_WAIT;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe (score and strobe appear together).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            p1_q        <= 3'd0;
            p2_q        <= 3'd0;
            pulse_cnt   <= 4'd0;
            strobe_p2   <= 1'b0;
            dir_q       <= 1'b0;
            win_q       <= 1'b0;
            p1_scored_q <= 1'b0;
            p2_scored_q <= 1'b0;
            hold_q      <= 1'b1;
            game_over_q <= 1'b0;
            left_prev   <= 1'b0;
            right_prev  <= 1'b0;
            ng_prev     <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            p1_q        <= p1_nx;
            p2_q        <= p2_nx;
            pulse_cnt   <= pulse_nx;
            strobe_p2   <= strobe_p2_nx;
            dir_q       <= dir_nx;
            win_q       <= win_nx;
            p1_scored_q <= (pulse_nx != 4'd0) && !strobe_p2_nx;
            p2_scored_q <= (pulse_nx != 4'd0) &&  strobe_p2_nx;
            hold_q      <= (state_nx != PLAY);
            game_over_q <= (state_nx == GAME_OVER);
            left_prev   <= bus.ball_out_left;
            right_prev  <= bus.ball_out_right;
            ng_prev     <= bus.new_game;
        end
    end

    assign bus.p1_score   = p1_q;
    assign bus.p2_score   = p2_q;
    assign bus.p1_scored  = p1_scored_q;
    assign bus.p2_scored  = p2_scored_q;
    assign bus.serve_hold = hold_q;
    assign bus.serve_dir  = dir_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = win_q;

endmodule
